wb_arbiter: RTL and testbench

Writeback arbiter that sits directly downstream of the execution-unit tops (divider, multiplier, ALU, load/store): it takes their early `wb_req_`/`pred_wb_rd` requests and grants one write slot per cycle with fair round-robin. It returns `wb_ack_`, broadcasts an early wakeup tag for dependent issue, and drives the single registered writeback bus into the register file and reorder buffer. All `_` suffixed signals are active-low.

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_rr.sv | 45 ++++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and its round-robin core.
//   WbArbUnits   - default number of requesting execution units
//   WbArbLatency - request-sample edge to registered writeback, in cycles
//   DataWidth    - default writeback data width
//   RegFile_t    - architectural register tag
//   ExpCode_t    - exception code carried alongside a result
package wb_arbiter_pkg;

    localparam int unsigned WbArbUnits   = 4;
    localparam int unsigned WbArbLatency = 3;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned ExpCodeWidth = 4;

    typedef logic [RegAddrWidth-1:0] RegFile_t;
    typedef logic [ExpCodeWidth-1:0] ExpCode_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin pick among active-low requests.
//   req_      in   per-unit request, active low
//   prio      in   index of the highest-priority unit
//   grant     out  one-hot grant, active high
//   grant_idx out  index of the granted unit
//   valid     out  at least one request was present
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned UNITS = WbArbUnits
) (
    input  logic [UNITS-1:0]         req_,
    input  logic [$clog2(UNITS)-1:0] prio,
    output logic [UNITS-1:0]         grant,
    output logic [$clog2(UNITS)-1:0] grant_idx,
    output logic                     valid
);

    localparam int unsigned IdxW = $clog2(UNITS);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;

    // Walk the units starting at prio; the first active request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int unsigned i = 0; i < UNITS; i++) begin
            sum = {1'b0, prio} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(UNITS)) begin
                sum = sum - (IdxW+1)'(UNITS);
            end
            cand = sum[IdxW-1:0];
            if (!valid && !req_[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: grants one writeback slot per cycle among execution units and
// drives the single registered writeback bus.
//   clk, reset_          clock, asynchronous active-low reset
//   flush_               synchronous pipeline flush, active low
//   req_, req_rd         per-unit writeback request and predicted destination
//   ack_                 per-unit grant, one-cycle low pulse
//   in_e_, in_rd, in_data, in_exp_, in_exp_code
//                        per-unit result bus, valid the cycle after ack_
//   wake_e_, wake_rd     early wakeup for dependent issue (grant cycle)
//   wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code
//                        registered writeback bus
//   proto_err_           sticky protocol-violation flag
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned UNITS = WbArbUnits,
    parameter int unsigned DATA  = DataWidth
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       flush_,
    input  logic [UNITS-1:0]           req_,
    input  RegFile_t [UNITS-1:0]       req_rd,
    output logic [UNITS-1:0]           ack_,
    input  logic [UNITS-1:0]           in_e_,
    input  RegFile_t [UNITS-1:0]       in_rd,
    input  logic [UNITS-1:0][DATA-1:0] in_data,
    input  logic [UNITS-1:0]           in_exp_,
    input  ExpCode_t [UNITS-1:0]       in_exp_code,
    output logic                       wake_e_,
    output RegFile_t                   wake_rd,
    output logic                       wb_e_,
    output RegFile_t                   wb_rd,
    output logic [DATA-1:0]            wb_data,
    output logic                       wb_exp_,
    output ExpCode_t                   wb_exp_code,
    output logic                       proto_err_
);

    localparam int unsigned IdxW   = $clog2(UNITS);
    // Stage 0 is the grant cycle, the last stage is the unit's result cycle.
    localparam int unsigned Stages = WbArbLatency - 1;
    localparam int unsigned Res    = Stages - 1;

    logic [UNITS-1:0] arb_grant;
    logic [IdxW-1:0]  arb_idx;
    logic             arb_valid;
    logic             gnt;

    logic [IdxW-1:0]  prio_q, prio_d;
    logic [UNITS-1:0] ack_q;  // active-low, one bit per unit

    // act: the unit was acked and will return a result.
    // ok:  that result has not been flushed since.
    logic [Stages-1:0]           act_q, ok_q;
    logic [Stages-1:0][IdxW-1:0] idx_q;
    RegFile_t [Stages-1:0]       tag_q;

    logic [IdxW-1:0]  res_idx;
    logic [UNITS-1:0] res_onehot;
    logic             res_e, wb_fire;
    logic             stray, missing, bad_rd;

    logic             wb_e_q, wb_exp_q, proto_err_q;
    RegFile_t         wb_rd_q;
    logic [DATA-1:0]  wb_data_q;
    ExpCode_t         wb_exp_code_q;

    rr_arbiter #(
        .UNITS (UNITS)
    ) u_rr (
        .req_      (req_),
        .prio      (prio_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // Flush wins over a grant in the same cycle and freezes the pointer.
    assign gnt = arb_valid & flush_;

    always_comb begin
        prio_d = prio_q;
        if (gnt) begin
            prio_d = (arb_idx == IdxW'(UNITS - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    // The result bus is selected by the registered grant index, not in_e_.
    always_comb begin
        res_idx    = idx_q[Res];
        res_onehot = UNITS'(act_q[Res]) << res_idx;
        res_e      = ~in_e_[res_idx];
        stray      = |(~in_e_ & ~res_onehot);
        missing    = act_q[Res] & ~res_e;
        bad_rd     = act_q[Res] & res_e & (in_rd[res_idx] != tag_q[Res]);
        wb_fire    = act_q[Res] & ok_q[Res] & flush_ & res_e;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            prio_q        <= '0;
            ack_q         <= '1;
            act_q         <= '0;
            ok_q          <= '0;
            idx_q         <= '0;
            tag_q         <= '0;
            wb_e_q        <= 1'b1;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_exp_q      <= 1'b1;
            wb_exp_code_q <= '0;
            proto_err_q   <= 1'b1;
        end else begin
            prio_q <= prio_d;
            ack_q  <= ~(arb_grant & {UNITS{gnt}});
            act_q  <= {act_q[Stages-2:0], gnt};
            ok_q   <= {ok_q[Stages-2:0] & {(Stages-1){flush_}}, gnt};
            idx_q  <= {idx_q[Stages-2:0], arb_idx};
            tag_q  <= {tag_q[Stages-2:0], req_rd[arb_idx]};
            wb_e_q <= ~wb_fire;
            if (wb_fire) begin
                wb_rd_q       <= in_rd[res_idx];
                wb_data_q     <= in_data[res_idx];
                wb_exp_q      <= in_exp_[res_idx];
                wb_exp_code_q <= in_exp_code[res_idx];
            end
            if (stray || missing || bad_rd) begin
                proto_err_q <= 1'b0;
            end
        end
    end

    assign ack_        = ack_q;
    assign wake_e_     = ~act_q[0];
    assign wake_rd     = tag_q[0];
    assign wb_e_       = wb_e_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_exp_     = wb_exp_q;
    assign wb_exp_code = wb_exp_code_q;
    assign proto_err_  = proto_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic, checked cycle by cycle against a timeline scoreboard.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int U    = WbArbUnits;
    localparam int D    = DataWidth;
    localparam int MAXC = 4096;

    logic                   clk;
    logic                   reset_;
    logic                   flush_;
    logic [U-1:0]           req_;
    RegFile_t [U-1:0]       req_rd;
    logic [U-1:0]           ack_;
    logic [U-1:0]           in_e_;
    RegFile_t [U-1:0]       in_rd;
    logic [U-1:0][D-1:0]    in_data;
    logic [U-1:0]           in_exp_;
    ExpCode_t [U-1:0]       in_exp_code;
    logic                   wake_e_;
    RegFile_t               wake_rd;
    logic                   wb_e_;
    RegFile_t               wb_rd;
    logic [D-1:0]           wb_data;
    logic                   wb_exp_;
    ExpCode_t               wb_exp_code;
    logic                   proto_err_;

    wb_arbiter #(
        .UNITS (U),
        .DATA  (D)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .flush_      (flush_),
        .req_        (req_),
        .req_rd      (req_rd),
        .ack_        (ack_),
        .in_e_       (in_e_),
        .in_rd       (in_rd),
        .in_data     (in_data),
        .in_exp_     (in_exp_),
        .in_exp_code (in_exp_code),
        .wake_e_     (wake_e_),
        .wake_rd     (wake_rd),
        .wb_e_       (wb_e_),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_exp_     (wb_exp_),
        .wb_exp_code (wb_exp_code),
        .proto_err_  (proto_err_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       unit;
        RegFile_t rd;
        logic [D-1:0] data;
        logic     x;
        ExpCode_t code;
    } rec_t;

    // Timeline scoreboard indexed by cycle number.
    rec_t ack_rec[MAXC];   // unit acked in that cycle
    rec_t wb_rec[MAXC];    // writeback expected in that cycle
    rec_t pend[U];         // each unit's outstanding request
    bit   busy[U];
    int   prio;
    int   cyc;
    bit   err_exp;
    int   n_total;
    int   n_bad;

    function automatic rec_t none_rec();
        rec_t r;
        r.unit = -1;
        r.rd   = '0;
        r.data = '0;
        r.x    = 1'b1;
        r.code = '0;
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < MAXC; c++) begin
            ack_rec[c] = none_rec();
            wb_rec[c]  = none_rec();
        end
        for (int j = 0; j < U; j++) begin
            busy[j] = 1'b0;
            pend[j] = none_rec();
        end
        prio    = 0;
        err_exp = 1'b0;
    endtask

    task automatic idle_inputs();
        flush_      = 1'b1;
        req_        = '1;
        req_rd      = '0;
        in_e_       = '1;
        in_rd       = '0;
        in_data     = '0;
        in_exp_     = '1;
        in_exp_code = '0;
    endtask

    task automatic check_reset_vals();
        check_val("rst ack_", ack_, {U{1'b1}});
        check_val("rst wake_e_", wake_e_, 1'b1);
        check_val("rst wake_rd", wake_rd, '0);
        check_val("rst wb_e_", wb_e_, 1'b1);
        check_val("rst wb_rd", wb_rd, '0);
        check_val("rst wb_data", wb_data, '0);
        check_val("rst wb_exp_", wb_exp_, 1'b1);
        check_val("rst wb_exp_code", wb_exp_code, '0);
        check_val("rst proto_err_", proto_err_, 1'b1);
    endtask

    // Predict the effect of the coming edge from the inputs the bench drives.
    task automatic model_edge();
        rec_t res;
        bit   found;
        int   u;
        res = (cyc > 0) ? ack_rec[cyc-1] : none_rec();
        for (int j = 0; j < U; j++) begin
            if (in_e_[j] == 1'b0 && res.unit != j) err_exp = 1'b1;
            if (res.unit == j) begin
                if (in_e_[j] == 1'b1) begin
                    err_exp        = 1'b1;
                    wb_rec[cyc+1]  = none_rec();
                end else if (in_rd[j] != res.rd) begin
                    err_exp           = 1'b1;
                    wb_rec[cyc+1].rd  = in_rd[j];
                end
            end
        end
        if (flush_ == 1'b0) begin
            wb_rec[cyc+1] = none_rec();
            wb_rec[cyc+2] = none_rec();
        end else begin
            found = 1'b0;
            for (int i = 0; i < U; i++) begin
                u = (prio + i) % U;
                if (!found && busy[u]) begin
                    found          = 1'b1;
                    ack_rec[cyc+1] = pend[u];
                    wb_rec[cyc+3]  = pend[u];
                    prio           = (u + 1) % U;
                end
            end
        end
    endtask

    task automatic tick();
        rec_t         a;
        rec_t         w;
        logic [U-1:0] ev;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        a  = ack_rec[cyc];
        ev = '1;
        for (int j = 0; j < U; j++) if (a.unit == j) ev[j] = 1'b0;
        check_val("ack_", ack_, ev);
        check_val("wake_e_", wake_e_, a.unit < 0);
        if (a.unit >= 0) check_val("wake_rd", wake_rd, a.rd);
        w = wb_rec[cyc];
        check_val("wb_e_", wb_e_, w.unit < 0);
        if (w.unit >= 0) begin
            check_val("wb_rd", wb_rd, w.rd);
            check_val("wb_data", wb_data, w.data);
            check_val("wb_exp_", wb_exp_, w.x);
            check_val("wb_exp_code", wb_exp_code, w.code);
        end
        check_val("proto_err_", proto_err_, !err_exp);
    endtask

    task automatic post(input int unit, input RegFile_t rd, input logic [D-1:0] data);
        busy[unit]      = 1'b1;
        pend[unit].unit = unit;
        pend[unit].rd   = rd;
        pend[unit].data = data;
        pend[unit].x    = 1'b1;
        pend[unit].code = '0;
    endtask

    // Behave like the execution units for the current cycle.
    task automatic drive(input bit [U-1:0] new_mask, input bit fl, input bit stray1,
                         input bit bad_rd);
        rec_t r;
        rec_t a;
        r     = (cyc > 0) ? ack_rec[cyc-1] : none_rec();
        a     = ack_rec[cyc];
        in_e_ = '1;
        for (int j = 0; j < U; j++) begin
            in_rd[j]       = RegFile_t'($urandom);
            in_data[j]     = D'($urandom);
            in_exp_[j]     = 1'($urandom);
            in_exp_code[j] = ExpCode_t'($urandom);
            if (r.unit == j) begin
                in_e_[j]       = 1'b0;
                in_rd[j]       = bad_rd ? (r.rd ^ RegFile_t'(1)) : r.rd;
                in_data[j]     = r.data;
                in_exp_[j]     = r.x;
                in_exp_code[j] = r.code;
            end
            if (a.unit == j) busy[j] = 1'b0;
        end
        if (stray1 && r.unit != 1) in_e_[1] = 1'b0;
        for (int j = 0; j < U; j++) begin
            if (new_mask[j] && !busy[j]) begin
                busy[j]      = 1'b1;
                pend[j].unit = j;
                pend[j].rd   = RegFile_t'($urandom);
                pend[j].data = D'($urandom);
                pend[j].x    = 1'($urandom);
                pend[j].code = ExpCode_t'($urandom);
            end
            req_[j]   = !busy[j];
            req_rd[j] = busy[j] ? pend[j].rd : RegFile_t'($urandom);
        end
        flush_ = !fl;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive('0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // Called just after an active edge: reset lands mid-cycle.
    task automatic do_reset();
        #2 reset_ = 1'b0;
        #1;
        check_reset_vals();
        clear_model();
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc     = 0;
        reset_  = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset_ = 1'b1;

        // Lone request from unit 2.
        post(2, RegFile_t'(5), 32'hDEAD_BEEF);
        run_idle(6);

        // All units continuously from reset.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive('1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        run_idle(8);

        // Move prio to 2, then units 1 and 3 together, then everyone once.
        post(1, RegFile_t'(7), 32'h0000_1111);
        run_idle(4);
        post(1, RegFile_t'(9), 32'h0000_2222);
        post(3, RegFile_t'(10), 32'h0000_3333);
        run_idle(5);
        drive('1, 1'b0, 1'b0, 1'b0);
        tick();
        run_idle(8);

        // Flush in unit 0's result cycle.
        post(0, RegFile_t'(3), 32'hCAFE_0000);
        drive('0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b1, 1'b0, 1'b0);
        tick();
        run_idle(3);
        post(0, RegFile_t'(4), 32'hCAFE_0001);
        run_idle(5);

        // Stray in_e_ from unit 1: sticky error.
        drive('0, 1'b0, 1'b1, 1'b0);
        tick();
        run_idle(4);
        do_reset();

        // Granted unit returns the wrong tag.
        post(0, RegFile_t'(12), 32'h1234_5678);
        drive('0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 1'b1);
        tick();
        run_idle(3);
        do_reset();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(U'($urandom_range(0, (1 << U) - 1)), $urandom_range(0, 19) == 0,
                  1'b0, 1'b0);
            tick();
        end
        run_idle(6);

        // Asynchronous reset in the middle of a full burst.
        prio = prio;
        for (int i = 0; i < 10; i++) begin
            drive('1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive('1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        run_idle(8);

        check_val("latency", WbArbLatency, 3);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
